// File: rtl/phy_rx_pkg.sv
// Shared PHY receive-side definitions.
// Holds the link FSM state encoding and the line symbols. The deserializer
// and the TX side use the same constants.
package phy_rx_pkg;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_LOCKING = 2'd1;
  localparam logic [1:0] ST_ACTIVE  = 2'd2;
  localparam logic [1:0] ST_LOSS    = 2'd3;

  typedef enum logic [1:0] {
    SEARCH  = ST_SEARCH,
    LOCKING = ST_LOCKING,
    ACTIVE  = ST_ACTIVE,
    LOSS    = ST_LOSS
  } rx_state_e;

  localparam logic [7:0] SYM_COMMA = 8'hBC;
  localparam logic [7:0] SYM_IDLE  = 8'h7C;

endpackage

// File: rtl/phy_rx_sat_counter.sv
// Saturating up-counter with a synchronous clear.
// Ports:
//   clk_4f  - byte clock (rising edge)
//   reset_L - asynchronous active-low reset
//   clr     - synchronous clear; it takes priority over inc
//   inc     - count up by one, holding at MAX
//   count   - current count (registered)
module phy_rx_sat_counter #(
  parameter int unsigned W   = 4,
  parameter int unsigned MAX = 15
) (
  input  logic         clk_4f,
  input  logic         reset_L,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX_V)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Receive-side link sync controller on the byte clock.
// The controller searches for LOCK_CNT consecutive valid commas and then
// declares the lane active. While the lane is active, it forwards payload
// bytes and drops comma/idle fill. LOSS_CNT consecutive invalid cycles drop
// the lane through a one-cycle LOSS state back to SEARCH.
// Ports:
//   clk_4f     - byte clock (rising edge)
//   reset_L    - asynchronous active-low reset
//   enable     - lane enable; when low, the lane returns to SEARCH
//   data_in    - byte from the deserializer
//   valid_in   - data_in qualifier
//   data_out   - forwarded payload byte (registered)
//   valid_out  - data_out qualifier
//   active_out - lane is in ACTIVE (asserts one cycle after entry)
//   state_out  - current FSM state
//   comma_cnt  - consecutive comma count, held at LOCK_CNT while ACTIVE
//   err_count  - saturating ACTIVE->LOSS count (only when PHY_RX_SYNC_ERR_CNT_EN is defined)
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0]  COMMA    = SYM_COMMA,
  parameter logic [7:0]  IDLE_SYM = SYM_IDLE,
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned LOSS_CNT = 3
) (
  input  logic       clk_4f,
  input  logic       reset_L,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active_out,
  output logic [1:0] state_out,
  output logic [3:0] comma_cnt
`ifdef PHY_RX_SYNC_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_V = 4'(LOSS_CNT);

  rx_state_e  state_q, state_d;
  logic [3:0] loss_q;
  logic       comma_inc, comma_clr, loss_inc, loss_clr;
  logic       is_comma, is_payload;

  assign is_comma   = valid_in && (data_in == COMMA);
  assign is_payload = valid_in && (data_in != COMMA) && (data_in != IDLE_SYM);
  assign state_out  = state_q;

  phy_rx_sat_counter #(.W(4), .MAX(LOCK_CNT)) u_comma_cnt (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .clr     (comma_clr),
    .inc     (comma_inc),
    .count   (comma_cnt)
  );

  phy_rx_sat_counter #(.W(4), .MAX(LOSS_CNT)) u_loss_cnt (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .clr     (loss_clr),
    .inc     (loss_inc),
    .count   (loss_q)
  );

  always_comb begin
    state_d   = state_q;
    comma_inc = 1'b0;
    comma_clr = 1'b0;
    loss_inc  = 1'b0;
    loss_clr  = 1'b0;
    if (!enable) begin
      state_d   = SEARCH;
      comma_clr = 1'b1;
      loss_clr  = 1'b1;
    end else begin
      case (state_q)
        SEARCH: begin
          loss_clr = 1'b1;
          if (is_comma) begin
            comma_inc = 1'b1;
            state_d   = (LOCK_V == 4'd1) ? ACTIVE : LOCKING;
          end else begin
            comma_clr = 1'b1;
          end
        end
        LOCKING: begin
          loss_clr = 1'b1;
          if (is_comma) begin
            comma_inc = 1'b1;
            if ((comma_cnt + 4'd1) == LOCK_V) state_d = ACTIVE;
          end else begin
            comma_clr = 1'b1;
            state_d   = SEARCH;
          end
        end
        ACTIVE: begin
          // comma_cnt is left alone so it holds LOCK_CNT while the lane is active.
          // Commas never count toward loss, so the loss condition takes precedence.
          if (valid_in) begin
            loss_clr = 1'b1;
          end else if (loss_q == (LOSS_V - 4'd1)) begin
            state_d   = LOSS;
            loss_clr  = 1'b1;
            comma_clr = 1'b1;
          end else begin
            loss_inc = 1'b1;
          end
        end
        LOSS: begin
          state_d   = SEARCH;
          comma_clr = 1'b1;
          loss_clr  = 1'b1;
        end
        default: begin
          state_d   = SEARCH;
          comma_clr = 1'b1;
          loss_clr  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q    <= SEARCH;
      data_out   <= 8'h00;
      valid_out  <= 1'b0;
      active_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_out  <= enable && (state_q == ACTIVE) && is_payload;
      // This flag is high from the second ACTIVE cycle. It drops when the
      // FSM leaves ACTIVE, so it already reads low during LOSS.
      active_out <= (state_q == ACTIVE) && (state_d == ACTIVE);
      if (enable && (state_q == ACTIVE) && is_payload) data_out <= data_in;
    end
  end

`ifdef PHY_RX_SYNC_ERR_CNT_EN
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      err_count <= 8'h00;
    end else if ((state_q == ACTIVE) && (state_d == LOSS) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Testbench for phy_rx_sync_ctrl. The bench runs directed steps for the main
// behaviours and then random segments. A behavioural lane model inside the
// bench checks every output.
module tb_phy_rx_sync_ctrl;

  localparam int LOCK = 4;
  localparam int LOSS = 3;

  logic       clk_4f = 1'b0;
  logic       reset_L = 1'b0;
  logic       enable = 1'b0;
  logic       valid_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       valid_out, active_out;
  logic [1:0] state_out;
  logic [3:0] comma_cnt;
`ifdef PHY_RX_SYNC_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  always #5 clk_4f = ~clk_4f;

  phy_rx_sync_ctrl #(.LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut (
    .clk_4f     (clk_4f),
    .reset_L    (reset_L),
    .enable     (enable),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .active_out (active_out),
    .state_out  (state_out),
    .comma_cnt  (comma_cnt)
`ifdef PHY_RX_SYNC_ERR_CNT_EN
    ,
    .err_count  (err_count)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // The model tracks the lane mode (0 search, 1 locking, 2 active, 3 loss),
  // the run of commas, the run of missing bytes and the expected outputs.
  int         m_mode, m_run, m_miss, m_err;
  bit         m_act, m_vld;
  logic [7:0] m_data;

  function automatic void model_reset();
    m_mode = 0; m_run = 0; m_miss = 0; m_err = 0;
    m_act = 1'b0; m_vld = 1'b0; m_data = 8'h00;
  endfunction

  function automatic void model_edge(bit en, bit v, logic [7:0] d);
    int prev = m_mode;
    m_vld = 1'b0;
    if (!en) begin
      m_mode = 0; m_run = 0; m_miss = 0;
    end else if (prev == 3) begin
      m_mode = 0; m_run = 0; m_miss = 0;
    end else if (prev == 2) begin
      if (v) begin
        m_miss = 0;
        if (d != 8'hBC && d != 8'h7C) begin
          m_vld = 1'b1;
          m_data = d;
        end
      end else begin
        m_miss = m_miss + 1;
        if (m_miss >= LOSS) begin
          m_mode = 3; m_run = 0; m_miss = 0;
          if (m_err < 255) m_err = m_err + 1;
        end
      end
    end else begin
      if (v && d == 8'hBC) begin
        m_run  = (m_run + 1 > LOCK) ? LOCK : m_run + 1;
        m_mode = (m_run >= LOCK) ? 2 : 1;
      end else begin
        m_mode = 0; m_run = 0;
      end
    end
    m_act = (prev == 2) && (m_mode == 2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/state"}, 32'(state_out), 32'(m_mode));
    chk({tag, "/comma_cnt"}, 32'(comma_cnt), 32'(m_run));
    chk({tag, "/active"}, 32'(active_out), 32'(m_act));
    chk({tag, "/valid"}, 32'(valid_out), 32'(m_vld));
    chk({tag, "/data"}, 32'(data_out), 32'(m_data));
`ifdef PHY_RX_SYNC_ERR_CNT_EN
    chk({tag, "/err_count"}, 32'(err_count), 32'(m_err));
`endif
  endtask

  task automatic step(input string tag, input bit en, input bit v, input logic [7:0] d);
    @(negedge clk_4f);
    enable = en; valid_in = v; data_in = d;
    @(posedge clk_4f);
    model_edge(en, v, d);
    #1 check_all(tag);
  endtask

  task automatic lock_up(input string tag);
    for (int i = 0; i < LOCK; i++) step(tag, 1'b1, 1'b1, 8'hBC);
  endtask

  initial begin
    model_reset();
    // Reset state
    @(posedge clk_4f);
    #1 check_all("reset");
    @(negedge clk_4f);
    reset_L = 1'b1;

    // Four commas lock the lane; active_out follows one cycle later
    lock_up("lock4");
    chk("lock4_state_active", 32'(state_out), 32'd2);
    chk("lock4_active_lag", 32'(active_out), 32'd0);
    step("lock4_idle", 1'b1, 1'b1, 8'h7C);
    chk("lock4_active_on", 32'(active_out), 32'd1);

    // A broken comma run restarts the search
    step("dis", 1'b0, 1'b0, 8'h00);
    step("brk_bc1", 1'b1, 1'b1, 8'hBC);
    step("brk_bc2", 1'b1, 1'b1, 8'hBC);
    step("brk_55", 1'b1, 1'b1, 8'h55);
    chk("brk_search", 32'(state_out), 32'd0);
    lock_up("brk_relock");
    chk("brk_active", 32'(state_out), 32'd2);

    // Payload is forwarded while idle and comma fill is dropped
    step("pay_a1", 1'b1, 1'b1, 8'hA1);
    chk("pay_a1_data", 32'(data_out), 32'hA1);
    step("pay_7c", 1'b1, 1'b1, 8'h7C);
    step("pay_bc", 1'b1, 1'b1, 8'hBC);
    chk("pay_hold_data", 32'(data_out), 32'hA1);
    step("pay_3f", 1'b1, 1'b1, 8'h3F);
    chk("pay_3f_vld", 32'(valid_out), 32'd1);
    chk("pay_3f_data", 32'(data_out), 32'h3F);

    // Three missing bytes cause loss, even with a comma on the bus in the third cycle
    step("loss1", 1'b1, 1'b0, 8'h00);
    step("loss2", 1'b1, 1'b0, 8'h00);
    step("loss3", 1'b1, 1'b0, 8'hBC);
    chk("loss_state", 32'(state_out), 32'd3);
    chk("loss_active", 32'(active_out), 32'd0);
`ifdef PHY_RX_SYNC_ERR_CNT_EN
    chk("loss_errcnt", 32'(err_count), 32'd1);
`endif
    step("loss_exit", 1'b1, 1'b1, 8'hBC);
    chk("loss_search", 32'(state_out), 32'd0);

    // Two missing bytes followed by a valid byte keep the lane up and restart the loss count
    lock_up("gap_lock");
    step("gap1", 1'b1, 1'b0, 8'h00);
    step("gap2", 1'b1, 1'b0, 8'h00);
    step("gap_ok", 1'b1, 1'b1, 8'h42);
    step("gap3", 1'b1, 1'b0, 8'h00);
    step("gap4", 1'b1, 1'b0, 8'h00);
    chk("gap_still_active", 32'(state_out), 32'd2);

    // Lowering enable while LOCKING at comma count 3 returns the lane to SEARCH
    step("en_dis", 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step("en_bc", 1'b1, 1'b1, 8'hBC);
    chk("en_cnt3", 32'(comma_cnt), 32'd3);
    step("en_low", 1'b0, 1'b1, 8'hBC);
    chk("en_low_cnt", 32'(comma_cnt), 32'd0);

    // Asserting reset in the middle of the payload clears every output at once
    lock_up("rst_lock");
    step("rst_a5", 1'b1, 1'b1, 8'hA5);
    @(negedge clk_4f);
    enable = 1'b1; valid_in = 1'b1; data_in = 8'h5A;
    #2 reset_L = 1'b0;
    model_reset();
    #1 check_all("rst_async");
    @(posedge clk_4f);
    #1 check_all("rst_hold");
    @(negedge clk_4f);
    reset_L = 1'b1;

    // Random segments: a lock preamble followed by biased random traffic
    for (int s = 0; s < 20; s++) begin
      int pv = $urandom_range(40, 95);
      lock_up("rnd_lock");
      for (int c = 0; c < 25; c++) begin
        int         r = $urandom_range(0, 9);
        logic [7:0] d;
        if (r < 4)      d = 8'hBC;
        else if (r < 5) d = 8'h7C;
        else            d = 8'($urandom);
        step("rnd", ($urandom_range(0, 99) != 0), ($urandom_range(0, 99) < pv), d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phy_rx_sync_ctrl.md
Name: phy_rx_sync_ctrl

Overview:
Receive-side link controller on the byte clock, downstream of the serial-to-parallel converter. Watches the recovered byte stream for the comma symbol 8'hBC and declares the lane active after enough consecutive commas. Once active, forwards payload bytes with a valid strobe and discards comma/idle fill. Declares loss of sync when input validity drops out, then returns to searching.

Parameters:
COMMA, 8'hBC, alignment/comma symbol
IDLE_SYM, 8'h7C, idle fill symbol, never forwarded
LOCK_CNT, 4, consecutive commas required to lock (range 1..15)
LOSS_CNT, 3, consecutive invalid cycles that drop lock (range 1..15)

Ports:
clk_4f  input  1  byte clock, all logic on rising edge
reset_L  input  1  asynchronous active-low reset
enable  input  1  lane enable; low forces the lane back to SEARCH
data_in  input  8  parallel byte from the deserializer
valid_in  input  1  data_in qualifies this cycle
data_out  output  8  forwarded payload byte, registered
valid_out  output  1  data_out qualifies this cycle
active_out  output  1  lane is in ACTIVE
state_out  output  2  current FSM state encoding
comma_cnt  output  4  current consecutive-comma count

Behaviour:
- Reset (reset_L low, async): state=SEARCH, data_out=8'h00, valid_out=0, active_out=0, comma_cnt=0, loss counter=0. All outputs are registered.
- States: SEARCH=2'd0, LOCKING=2'd1, ACTIVE=2'd2, LOSS=2'd3.
- enable low in any state: next state SEARCH, counters cleared, valid_out=0. enable takes priority over every transition below.
- SEARCH: valid_in and data_in==COMMA sets comma_cnt=1 and moves to LOCKING. If LOCK_CNT==1, it moves straight to ACTIVE instead. Any other input stays in SEARCH.
- LOCKING: valid_in and COMMA increments comma_cnt. Reaching LOCK_CNT moves to ACTIVE. Non-comma valid byte, or valid_in low, returns to SEARCH with comma_cnt=0.
- ACTIVE: active_out=1, registered, so it asserts in the cycle after entry.
  - valid_in high and data_in is neither COMMA nor IDLE_SYM: data_out<=data_in and valid_out<=1. One-cycle latency.
  - Commas and idles in ACTIVE produce valid_out=0, and data_out holds its last value.
  - valid_in low increments the loss counter. Any valid_in high clears it.
  - Loss counter reaching LOSS_CNT moves to LOSS.
- LOSS: held for exactly one cycle. valid_out=0, active_out falls, counters cleared, then unconditional transition to SEARCH.
- comma_cnt saturates at LOCK_CNT and holds that value throughout ACTIVE.
- A comma arriving in the same cycle the loss threshold is reached: loss wins.
- Reset asserted mid-payload: outputs clear immediately, with no partial byte emitted.

Optional Feature:
- Macro: PHY_RX_SYNC_ERR_CNT_EN.
- Defined: adds output err_count[7:0], a saturating count of ACTIVE->LOSS transitions. It clears only on reset and holds at 8'hFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package phy_rx_pkg holds the state encoding localparams (SEARCH/LOCKING/ACTIVE/LOSS) and the symbol constants 8'hBC and 8'h7C, shared with the deserializer and the TX side.
- One natural sub-module, phy_rx_sat_counter: a 4-bit saturating counter with clear, instanced for the comma count and the loss count.
- FSM and output registers stay in the top module.

Test Plan:
- Reset then 4 valid 8'hBC -> state reaches ACTIVE after the 4th comma; active_out=1 one cycle later; valid_out stays 0 throughout.
- BC,BC,8'h55,BC,BC,BC,BC -> state returns to SEARCH on 8'h55; ACTIVE is reached only after the last 4 commas.
- In ACTIVE, send 8'hA1,8'h7C,8'hBC,8'h3F -> valid_out pulses twice, with data_out 8'hA1 and 8'h3F, each one cycle after input.
- In ACTIVE, drop valid_in for 3 cycles -> one LOSS cycle, active_out=0, then SEARCH; with the macro defined, err_count=1.
- In ACTIVE, drop valid_in for 2 cycles then restore it -> stays in ACTIVE and the loss counter clears.
- enable low during LOCKING at comma_cnt=3, and separately reset_L low mid-payload -> SEARCH with counters 0 and all outputs 0 immediately.
